// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result handshake plus the adder operand and result buses
interface seq_multiplier_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  modport master (
    output start, op_a, op_b, add_sum, add_cout,
    input  busy, done, product_hi, product_lo, add_a, add_b, add_cin
  );
  modport slave (
    input  start, op_a, op_b, add_sum, add_cout,
    output busy, done, product_hi, product_lo, add_a, add_b, add_cin
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 unsigned shift-and-add multiplier iterating through the shared external adder
module seq_multiplier (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [31:0] mcand_q;
  logic [31:0] acc_q;
  logic [31:0] mplr_q;
  logic [4:0]  cnt_q;
  logic [63:0] shift_d;
  // carry-out becomes the new acc MSB so the 65-bit partial sum never loses a bit
  assign shift_d        = {bus.add_cout, bus.add_sum, mplr_q[31:1]};
  assign bus.add_a      = acc_q;
  assign bus.add_b      = mplr_q[0] ? mcand_q : 32'h0;
  assign bus.add_cin    = 1'b0;
  assign bus.product_hi = acc_q;
  assign bus.product_lo = mplr_q;
  assign bus.busy       = state_q == RUN;
  assign bus.done       = state_q == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand_q <= bus.op_a;
            acc_q   <= '0;
            mplr_q  <= bus.op_b;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          {acc_q, mplr_q} <= shift_d;
          cnt_q           <= cnt_q + 5'd1;
          state_q         <= cnt_q == 5'd31 ? DONE : RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative 32x32 unsigned shift-and-add multiplier producing a 64-bit product in 32 iterations. It sits directly upstream of the 32-bit hybrid adder. Each cycle it drives the adder's operand inputs from its partial-product register and consumes the adder's sum and carry-out. It exists so the ALU can implement a multiply instruction by reusing the existing adder instead of adding a combinational array multiplier.

## Interface
- No parameters; the width is fixed at 32 bits to match the adder.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply. Sampled only in IDLE and DONE.
- op_a  in  32  multiplicand, captured when start is accepted.
- op_b  in  32  multiplier, captured when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; product valid.
- product_hi  out  32  upper product word.
- product_lo  out  32  lower product word.
- add_a  out  32  adder operand a.
- add_b  out  32  adder operand b.
- add_cin  out  1  adder carry-in, tied to 0.
- add_sum  in  32  adder sum S.
- add_cout  in  1  adder carry-out.

## Operation
- Registers:
  - mcand[31:0]
  - acc[31:0], the upper partial product
  - mplr[31:0], the lower partial product and remaining multiplier bits
  - cnt[4:0]
  - FSM state
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: load mcand=op_a, acc=0, mplr=op_b, cnt=0; go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN: perform one iteration per cycle. When cnt==31 and the iteration completes, go to DONE; otherwise increment cnt.
  - DONE: if start=1, load new operands exactly as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Adder drive (combinational from registers):
  - add_a = acc
  - add_b = mplr[0] ? mcand : 32'h0
  - add_cin = 0
- Iteration update: {acc, mplr} <= {add_cout, add_sum, mplr[31:1]}. This is a 65-bit value shifted right by one and truncated to 64 bits.
- Width rule: add_cout supplies bit 31 of the new acc, so no carry is ever lost. The final {acc, mplr} equals op_a*op_b modulo 2^64, which for unsigned 32-bit operands is exact.
- Outputs:
  - product_hi = acc and product_lo = mplr, registered.
  - Values in IDLE and DONE hold the last completed result until the next start is accepted.
  - During RUN the product outputs show intermediate values and are undefined for consumers.
- busy = (state==RUN).
- done = (state==DONE).
- start while in RUN is ignored; operands are not re-captured.

## Timing
- Reset values: state=IDLE; busy=0, done=0, product_hi=0, product_lo=0, add_a=0, add_b=0, add_cin=0; cnt=0.
- Reset asserted in any state, including mid-RUN, aborts the operation. After that edge all of the reset values above hold. No done pulse is produced for the aborted operation.
- Latency:
  - start sampled high at edge E0 puts the FSM in RUN.
  - The 32 iterations occur at edges E1 through E32.
  - done is high for exactly the one cycle after E32, with the product valid in that same cycle.
  - Start to done is 33 cycles.
- Throughput: a start held high through DONE is accepted at edge E33. New RUN begins with no idle gap, giving one result every 33 cycles.
- The adder is purely combinational. add_sum and add_cout must settle within one clock period of add_a/add_b changing; no stall or handshake exists on the adder side.
- If start and rst are high at the same edge, rst wins.

## Test plan
- 3 × 5: start with op_a=3, op_b=5 -> done exactly 33 cycles later with product_hi=0, product_lo=15; busy high for 32 cycles.
- Full-width carry: 0xFFFFFFFF × 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001. A second case 0xFFFFFFFF × 2 -> 0x00000001_FFFFFFFE. Together these check the add_cout path.
- Zero and identity: 0 × 0x12345678 -> product 0. 0x12345678 × 1 -> product_hi=0, product_lo=0x12345678. add_b must be 0 in every cycle where mplr[0]=0.
- Start ignored in RUN: start 7 × 9, pulse start with op_a=100, op_b=100 at cycle 10 of RUN -> result is still 63, done still at cycle 33, no second operation starts.
- Reset mid-operation: assert rst at cycle 15 of RUN -> next cycle busy=0, done=0, product=0, state IDLE. A following start 6 × 7 yields 42 after 33 cycles.
- Back-to-back: hold start high with 2 × 3, then 4 × 5 presented during the DONE cycle -> done pulses at cycles 33 and 66 with products 6 and 20; busy low only during the DONE cycles.
